// File: rtl/run_symbol_gen.sv
`default_nettype none
// ============================================================================
// Module   : run_symbol_gen
// Purpose  : Transmit-side stimulus source for the 2-bit run detector.
//            On a start request it drives w with len class-A symbols
//            (00/11), then one class-B break symbol (01/10). An LFSR picks
//            the symbol within each class. Alongside w it keeps a
//            cycle-accurate model of the detector (expect_x, expect_idle).
// Ports    : clk         - rising-edge clock
//            rst         - synchronous active-low reset
//            start       - run request, sampled only in IDLE
//            len         - class-A run length, latched on accepted start
//            w           - registered symbol to the detector
//            busy        - high while a run or break is on w
//            done        - one-cycle pulse in the first IDLE cycle after break
//            expect_x    - predicted detector x
//            expect_idle - predicted detector InIdle
// Revision : 1.0 - initial release
// ============================================================================
module run_symbol_gen #(
  parameter int         LEN_W      = 4,
  parameter int         RUN_TARGET = 4,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [1:0]       w,
  output logic             busy,
  output logic             done,
  output logic             expect_x,
  output logic             expect_idle
);

  localparam logic [LEN_W-1:0] c_RUN_TARGET = LEN_W'(RUN_TARGET);
  localparam logic [1:0]       c_IDLE_SYM   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BREAK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_w;
  logic [1:0]       w_w_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [7:0]       r_lfsr;
  logic [7:0]       w_lfsr_nxt;
  logic [7:0]       w_lfsr_step;
  logic [LEN_W-1:0] r_len_l;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] r_sym_cnt;
  logic [LEN_W-1:0] w_sym_cnt_nxt;
  logic [LEN_W-1:0] r_run_cnt;
  logic             w_class_a;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // The symbol registered at an edge is chosen from the LFSR value that will
  // be current in the cycle it appears, so the first run symbol uses SEED.
  always_comb begin
    w_state_nxt   = r_state;
    w_w_nxt       = c_IDLE_SYM;
    w_done_nxt    = 1'b0;
    w_lfsr_nxt    = r_lfsr;
    w_len_nxt     = r_len_l;
    w_sym_cnt_nxt = r_sym_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_state_nxt   = S_RUN;
            w_len_nxt     = len;
            w_sym_cnt_nxt = '0;
            w_w_nxt       = r_lfsr[0] ? 2'b11 : 2'b00;
          end else begin
            w_state_nxt = S_BREAK;
            w_w_nxt     = r_lfsr[0] ? 2'b10 : 2'b01;
          end
        end
      end
      S_RUN: begin
        w_lfsr_nxt    = w_lfsr_step;
        w_sym_cnt_nxt = r_sym_cnt + 1'b1;
        if (r_sym_cnt == r_len_l - 1'b1) begin
          w_state_nxt = S_BREAK;
          w_w_nxt     = w_lfsr_step[0] ? 2'b10 : 2'b01;
        end else begin
          w_w_nxt     = w_lfsr_step[0] ? 2'b11 : 2'b00;
        end
      end
      S_BREAK: begin
        w_lfsr_nxt  = w_lfsr_step;
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_w       <= c_IDLE_SYM;
      r_done    <= 1'b0;
      r_lfsr    <= SEED;
      r_len_l   <= '0;
      r_sym_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_w       <= w_w_nxt;
      r_done    <= w_done_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_len_l   <= w_len_nxt;
      r_sym_cnt <= w_sym_cnt_nxt;
    end
  end

  // Detector model: saturating count of consecutive class-A symbols seen on w.
  assign w_class_a = (r_w[1] == r_w[0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run_cnt <= '0;
    end else if (w_class_a) begin
      if (r_run_cnt != c_RUN_TARGET) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end else begin
      r_run_cnt <= '0;
    end
  end

  assign w           = r_w;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign expect_x    = (r_run_cnt == c_RUN_TARGET);
  assign expect_idle = (r_run_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_run_symbol_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_symbol_gen
// Purpose  : Scoreboard bench for run_symbol_gen. A symbol-plan model turns
//            each accepted request into a list of future output cycles; a
//            monitor compares every DUT cycle against the queued expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_symbol_gen;

  localparam int         LEN_W      = 4;
  localparam int         RUN_TARGET = 4;
  localparam logic [7:0] SEED       = 8'hA5;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len   = '0;
  logic [1:0]       w;
  logic             busy;
  logic             done;
  logic             expect_x;
  logic             expect_idle;

  run_symbol_gen #(
    .LEN_W      (LEN_W),
    .RUN_TARGET (RUN_TARGET),
    .SEED       (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .w           (w),
    .busy        (busy),
    .done        (done),
    .expect_x    (expect_x),
    .expect_idle (expect_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] w;
    logic       busy;
    logic       done;
    logic       x;
    logic       idle;
  } obs_t;

  obs_t q[$];      // one expected observation per upcoming cycle
  obs_t plan[$];   // remaining cycles of the transfer in progress

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] m_lfsr = SEED;
  int         m_cnt  = 0;
  logic [1:0] m_w    = 2'b01;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Predicts the outputs of the cycle that follows the coming rising edge.
  task automatic model_edge(input logic r, input logic s, input logic [LEN_W-1:0] l);
    obs_t e;
    if (!r) begin
      plan.delete();
      m_lfsr = SEED;
      m_cnt  = 0;
      e      = '{w: 2'b01, busy: 1'b0, done: 1'b0, x: 1'b0, idle: 1'b1};
    end else begin
      if (m_w == 2'b00 || m_w == 2'b11)
        m_cnt = (m_cnt + 1 > RUN_TARGET) ? RUN_TARGET : m_cnt + 1;
      else
        m_cnt = 0;
      if (plan.size() == 0 && s) begin
        for (int i = 0; i < int'(l); i++) begin
          plan.push_back('{w: (m_lfsr[0] ? 2'b11 : 2'b00), busy: 1'b1, done: 1'b0, x: 1'b0, idle: 1'b0});
          m_lfsr = lfsr_step(m_lfsr);
        end
        plan.push_back('{w: (m_lfsr[0] ? 2'b10 : 2'b01), busy: 1'b1, done: 1'b0, x: 1'b0, idle: 1'b0});
        m_lfsr = lfsr_step(m_lfsr);
        plan.push_back('{w: 2'b01, busy: 1'b0, done: 1'b1, x: 1'b0, idle: 1'b0});
      end
      if (plan.size() != 0) e = plan.pop_front();
      else                  e = '{w: 2'b01, busy: 1'b0, done: 1'b0, x: 1'b0, idle: 1'b0};
      e.x    = (m_cnt == RUN_TARGET);
      e.idle = (m_cnt == 0);
    end
    m_w = e.w;
    q.push_back(e);
  endtask

  task automatic apply(input logic r, input logic s, input logic [LEN_W-1:0] l);
    @(negedge clk);
    rst   = r;
    start = s;
    len   = l;
    model_edge(r, s, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, 1'b0, '0);
  endtask

  // Monitor: every cycle is an output observation.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = '{w: w, busy: busy, done: done, x: expect_x, idle: expect_idle};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle_obs t=%0t got w=%b busy=%b done=%b x=%b idle=%b expected w=%b busy=%b done=%b x=%b idle=%b",
                   $time, got.w, got.busy, got.done, got.x, got.idle,
                   e.w, e.busy, e.done, e.x, e.idle);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1);
  end

  initial begin
    logic             r_r;
    logic             r_s;
    logic [LEN_W-1:0] r_l;

    apply(1'b0, 1'b0, '0);
    apply(1'b0, 1'b0, '0);
    idle(3);

    apply(1'b1, 1'b1, 4'd4);  idle(8);
    apply(1'b1, 1'b1, 4'd3);  idle(7);

    // Fresh seed so the 15-symbol run follows the LFSR sequence from SEED.
    apply(1'b0, 1'b0, '0);    idle(2);
    apply(1'b1, 1'b1, 4'd15); idle(18);

    apply(1'b1, 1'b1, 4'd0);  idle(4);

    // Second start during RUN must be ignored.
    apply(1'b1, 1'b1, 4'd6);
    idle(2);
    apply(1'b1, 1'b1, 4'd9);
    idle(8);

    // Reset at k+3 of a len=8 run, then a len=4 run from SEED.
    apply(1'b1, 1'b1, 4'd8);
    idle(2);
    apply(1'b0, 1'b0, '0);
    idle(2);
    apply(1'b1, 1'b1, 4'd4);  idle(7);

    // Start held high: back-to-back runs accepted in the done cycle.
    for (int i = 0; i < 12; i++) apply(1'b1, 1'b1, 4'd2);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 99) != 0);
      r_s = ($urandom_range(0, 3) == 0);
      r_l = LEN_W'($urandom);
      apply(r_r, r_s, r_l);
    end
    idle(3);

    @(posedge clk);
    #4;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
